// File: rtl/sccb_target.sv
// SCCB/I2C target: decodes START/STOP, matches a 7-bit device address and
// serves register writes/reads against an internal 256x8 register file.
module sccb_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] reg_rd_addr,
    output logic [7:0] reg_rd_data,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DEV_ADDR = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_REG_ADDR = 4'd3,
        ST_REG_ACK  = 4'd4,
        ST_WR_DATA  = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD_DATA  = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_IGNORE   = 4'd9
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_hist_r;
    logic                   sda_hist_r;

    logic scl_s;
    logic sda_s;
    logic start_s;
    logic stop_s;
    logic scl_rise_s;
    logic scl_fall_s;

    state_t     state_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic [7:0] ptr_r;
    logic       phase_r;
    logic       rw_r;
    logic       sda_oe_r;
    logic       busy_r;
    logic       wr_valid_r;
    logic [7:0] wr_addr_r;
    logic [7:0] wr_data_r;

    state_t     state_nxt_s;
    logic [2:0] bit_cnt_nxt_s;
    logic [7:0] shift_nxt_s;
    logic [7:0] ptr_nxt_s;
    logic       phase_nxt_s;
    logic       rw_nxt_s;
    logic       sda_oe_nxt_s;
    logic       busy_nxt_s;
    logic       wr_valid_nxt_s;
    logic [7:0] wr_addr_nxt_s;
    logic [7:0] wr_data_nxt_s;
    logic       reg_we_s;

    logic [7:0] regs_r [256];
    logic [7:0] byte_s;
    logic [7:0] rd_byte_s;

    // Pin synchronizers and edge history; left free-running through reset so
    // that releasing reset never fabricates a START or STOP.
    always_ff @(posedge clk) begin
        scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
        sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
        scl_hist_r <= scl_sync_r[SYNC_STAGES-1];
        sda_hist_r <= sda_sync_r[SYNC_STAGES-1];
    end

    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign start_s    = scl_s & scl_hist_r & sda_hist_r & ~sda_s;
    assign stop_s     = scl_s & scl_hist_r & ~sda_hist_r & sda_s;
    assign scl_rise_s = scl_s & ~scl_hist_r;
    assign scl_fall_s = ~scl_s & scl_hist_r;

    assign byte_s    = {shift_r[6:0], sda_s};
    assign rd_byte_s = regs_r[ptr_r];

    // Protocol state machine: next state and all next register values.
    always_comb begin
        state_nxt_s    = state_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        ptr_nxt_s      = ptr_r;
        phase_nxt_s    = phase_r;
        rw_nxt_s       = rw_r;
        sda_oe_nxt_s   = sda_oe_r;
        busy_nxt_s     = busy_r;
        wr_valid_nxt_s = 1'b0;
        wr_addr_nxt_s  = wr_addr_r;
        wr_data_nxt_s  = wr_data_r;
        reg_we_s       = 1'b0;

        if (start_s) begin
            state_nxt_s   = ST_DEV_ADDR;
            bit_cnt_nxt_s = 3'd0;
            phase_nxt_s   = 1'b0;
            sda_oe_nxt_s  = 1'b0;
        end else if (stop_s) begin
            state_nxt_s   = ST_IDLE;
            bit_cnt_nxt_s = 3'd0;
            phase_nxt_s   = 1'b0;
            sda_oe_nxt_s  = 1'b0;
            busy_nxt_s    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_IGNORE: begin
                    state_nxt_s = state_r;
                end

                ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
                    if (scl_rise_s) begin
                        shift_nxt_s   = byte_s;
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            phase_nxt_s = 1'b0;
                            if (state_r == ST_DEV_ADDR) begin
                                if (byte_s[7:1] == DEV_ADDR) begin
                                    state_nxt_s = ST_ADDR_ACK;
                                    busy_nxt_s  = 1'b1;
                                    rw_nxt_s    = byte_s[0];
                                end else begin
                                    state_nxt_s = ST_IGNORE;
                                    busy_nxt_s  = 1'b0;
                                end
                            end else if (state_r == ST_REG_ADDR) begin
                                ptr_nxt_s   = byte_s;
                                state_nxt_s = ST_REG_ACK;
                            end else begin
                                reg_we_s       = 1'b1;
                                wr_valid_nxt_s = 1'b1;
                                wr_addr_nxt_s  = ptr_r;
                                wr_data_nxt_s  = byte_s;
                                ptr_nxt_s      = ptr_r + 8'd1;
                                state_nxt_s    = ST_WR_ACK;
                            end
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end

                // First fall pulls SDA for the ACK, second fall ends the slot.
                ST_ADDR_ACK, ST_REG_ACK, ST_WR_ACK: begin
                    if (scl_fall_s) begin
                        if (!phase_r) begin
                            sda_oe_nxt_s = 1'b1;
                            phase_nxt_s  = 1'b1;
                        end else begin
                            phase_nxt_s   = 1'b0;
                            bit_cnt_nxt_s = 3'd0;
                            if ((state_r == ST_ADDR_ACK) && rw_r) begin
                                state_nxt_s  = ST_RD_DATA;
                                shift_nxt_s  = {rd_byte_s[6:0], 1'b0};
                                sda_oe_nxt_s = ~rd_byte_s[7];
                            end else if (state_r == ST_ADDR_ACK) begin
                                state_nxt_s  = ST_REG_ADDR;
                                sda_oe_nxt_s = 1'b0;
                            end else begin
                                state_nxt_s  = ST_WR_DATA;
                                sda_oe_nxt_s = 1'b0;
                            end
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end

                // phase_r marks that all 8 bits have been clocked out.
                ST_RD_DATA: begin
                    if (scl_rise_s) begin
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            phase_nxt_s = 1'b1;
                        end else begin
                            phase_nxt_s = phase_r;
                        end
                    end else if (scl_fall_s) begin
                        if (phase_r) begin
                            sda_oe_nxt_s = 1'b0;
                            phase_nxt_s  = 1'b0;
                            ptr_nxt_s    = ptr_r + 8'd1;
                            state_nxt_s  = ST_RD_ACK;
                        end else begin
                            sda_oe_nxt_s = ~shift_r[7];
                            shift_nxt_s  = {shift_r[6:0], 1'b0};
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end

                ST_RD_ACK: begin
                    if (scl_rise_s) begin
                        if (sda_s) begin
                            state_nxt_s = ST_IGNORE;
                        end else begin
                            phase_nxt_s = 1'b1;
                        end
                    end else if (scl_fall_s && phase_r) begin
                        state_nxt_s   = ST_RD_DATA;
                        phase_nxt_s   = 1'b0;
                        bit_cnt_nxt_s = 3'd0;
                        shift_nxt_s   = {rd_byte_s[6:0], 1'b0};
                        sda_oe_nxt_s  = ~rd_byte_s[7];
                    end else begin
                        state_nxt_s = state_r;
                    end
                end

                default: begin
                    state_nxt_s  = ST_IDLE;
                    sda_oe_nxt_s = 1'b0;
                    busy_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // Protocol state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            ptr_r      <= 8'h00;
            phase_r    <= 1'b0;
            rw_r       <= 1'b0;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            wr_valid_r <= 1'b0;
            wr_addr_r  <= 8'h00;
            wr_data_r  <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            ptr_r      <= ptr_nxt_s;
            phase_r    <= phase_nxt_s;
            rw_r       <= rw_nxt_s;
            sda_oe_r   <= sda_oe_nxt_s;
            busy_r     <= busy_nxt_s;
            wr_valid_r <= wr_valid_nxt_s;
            wr_addr_r  <= wr_addr_nxt_s;
            wr_data_r  <= wr_data_nxt_s;
        end
    end

    // Register file: cleared by reset, written by the bus at the end of a data byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (reg_we_s) begin
            regs_r[ptr_r] <= byte_s;
        end
    end

    assign sda_oe      = sda_oe_r;
    assign busy        = busy_r;
    assign wr_valid    = wr_valid_r;
    assign wr_addr     = wr_addr_r;
    assign wr_data     = wr_data_r;
    assign reg_rd_data = regs_r[reg_rd_addr];

endmodule

// File: tb/tb_sccb_target.sv
// Self-checking bench for sccb_target: bus-master tasks, transaction-level
// register model, and a wr_valid scoreboard monitor.
module tb_sccb_target;

    localparam int         QTR     = 5;
    localparam logic [7:0] WR_BYTE = 8'h42;
    localparam logic [7:0] RD_BYTE = 8'h43;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] reg_rd_addr;
    logic [7:0] reg_rd_data;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  model_regs [256];
    logic [7:0]  model_ptr;
    logic [15:0] exp_wr_q [$];
    logic [7:0]  tx_q [$];
    bit          quiet_watch = 1'b0;
    bit          saw_activity = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    sccb_target #(.DEV_ADDR(7'h21), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .scl         (scl_m),
        .sda_i       (sda_line),
        .sda_oe      (sda_oe),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic q();
        repeat (QTR) @(posedge clk);
        #1;
    endtask

    task automatic clock_bit(input logic b, output logic seen);
        q(); sda_m = b;
        q(); scl_m = 1'b1;
        q(); seen = sda_line;
        q(); scl_m = 1'b0;
    endtask

    task automatic bus_start();
        q(); sda_m = 1'b1;
        q(); scl_m = 1'b1;
        q(); sda_m = 1'b0;
        q(); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        q(); sda_m = 1'b0;
        q(); scl_m = 1'b1;
        q(); sda_m = 1'b1;
        q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], dummy);
        clock_bit(1'b1, ack);
    endtask

    task automatic fab_check(input logic [7:0] addr);
        reg_rd_addr = addr;
        #1;
        check("fabric_read", {24'h0, reg_rd_data}, {24'h0, model_regs[addr]});
    endtask

    // Write transaction from tx_q: first byte is the register address, rest are data.
    task automatic wr_txn(input logic [7:0] dev, input bit do_stop);
        logic ack;
        logic exp_ack;
        bit   hit;
        hit     = (dev == WR_BYTE);
        exp_ack = hit ? 1'b0 : 1'b1;
        if (!hit) begin
            saw_activity = 1'b0;
            quiet_watch  = 1'b1;
        end
        bus_start();
        write_byte(dev, ack);
        check("dev_ack", ack, exp_ack);
        if (hit) check("busy_on", busy, 1'b1);
        for (int i = 0; i < tx_q.size(); i++) begin
            if (hit) begin
                if (i == 0) begin
                    model_ptr = tx_q[0];
                end else begin
                    model_regs[model_ptr] = tx_q[i];
                    exp_wr_q.push_back({model_ptr, tx_q[i]});
                    model_ptr = model_ptr + 8'd1;
                end
            end
            write_byte(tx_q[i], ack);
            check(hit ? "data_ack" : "ignored_nack", ack, exp_ack);
        end
        if (do_stop) begin
            bus_stop();
            check("busy_off", busy, 1'b0);
        end
        if (!hit) begin
            quiet_watch = 1'b0;
            check("ignored_quiet", saw_activity, 1'b0);
        end
    endtask

    // Read n bytes from the current pointer; master NACKs the last one.
    task automatic rd_txn(input int n);
        logic       ack;
        logic       bitv;
        logic [7:0] got;
        logic [7:0] exp;
        bus_start();
        write_byte(RD_BYTE, ack);
        check("rd_dev_ack", ack, 1'b0);
        for (int k = 0; k < n; k++) begin
            exp       = model_regs[model_ptr];
            model_ptr = model_ptr + 8'd1;
            got       = 8'h00;
            for (int i = 0; i < 8; i++) begin
                clock_bit(1'b1, bitv);
                got = {got[6:0], bitv};
            end
            clock_bit((k == n - 1) ? 1'b1 : 1'b0, bitv);
            check("rd_data", {24'h0, got}, {24'h0, exp});
        end
        repeat (4) @(posedge clk);
        #1;
        check("oe_after_nack", sda_oe, 1'b0);
        bus_stop();
        check("busy_off_rd", busy, 1'b0);
    endtask

    // Scoreboard monitor: every wr_valid pulse must match the oldest expected write.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (quiet_watch && (busy || sda_oe)) saw_activity = 1'b1;
            if (wr_valid) begin
                if (exp_wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wr_event: unexpected pulse addr 0x%0h data 0x%0h", wr_addr, wr_data);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_event", {16'h0, wr_addr, wr_data}, {16'h0, e});
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic       dummy;
        logic [7:0] dev;
        int         kind;
        int         nb;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; reg_rd_addr = 8'h00;
        for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
        model_ptr = 8'h00;
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_addr", wr_addr, 8'h00);
        check("rst_wr_data", wr_data, 8'h00);
        fab_check(8'h00);
        fab_check(8'hFF);

        // Single write
        tx_q = '{8'h12, 8'h80};
        wr_txn(WR_BYTE, 1'b1);
        fab_check(8'h12);

        // Burst wrapping the pointer past 0xFF
        tx_q = '{8'hFE, 8'h11, 8'h22, 8'h33};
        wr_txn(WR_BYTE, 1'b1);
        fab_check(8'hFE);
        fab_check(8'hFF);
        fab_check(8'h00);

        // Two-phase read
        tx_q = '{8'h0A, 8'h5A, 8'hC3};
        wr_txn(WR_BYTE, 1'b1);
        tx_q = '{8'h0A};
        wr_txn(WR_BYTE, 1'b1);
        rd_txn(2);

        // Foreign address is ignored
        tx_q = '{8'h01, 8'h02, 8'h03};
        wr_txn(8'h60, 1'b1);

        // Repeated START mid-write turns into a read
        tx_q = '{8'h20, 8'hA7};
        wr_txn(WR_BYTE, 1'b1);
        tx_q = '{8'h20};
        wr_txn(WR_BYTE, 1'b0);
        rd_txn(1);

        // Reset in the middle of a data byte
        bus_start();
        write_byte(WR_BYTE, ack);
        check("rst_txn_dev_ack", ack, 1'b0);
        write_byte(8'h33, ack);
        check("rst_txn_reg_ack", ack, 1'b0);
        for (int i = 0; i < 4; i++) clock_bit(i[0], dummy);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
        model_ptr = 8'h00;
        #1;
        check("midrst_sda_oe", sda_oe, 1'b0);
        check("midrst_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) clock_bit(1'b0, dummy);
        clock_bit(1'b1, ack);
        check("midrst_nack", ack, 1'b1);
        bus_stop();
        for (int i = 0; i < 256; i++) fab_check(8'(i));
        tx_q = '{8'h05, 8'h99};
        wr_txn(WR_BYTE, 1'b1);
        fab_check(8'h05);

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            kind = int'($urandom_range(0, 3));
            tx_q.delete();
            tx_q.push_back(8'($urandom_range(0, 255)));
            case (kind)
                0, 1: begin
                    nb = int'($urandom_range(1, 4));
                    for (int j = 0; j < nb; j++) tx_q.push_back(8'($urandom_range(0, 255)));
                    wr_txn(WR_BYTE, 1'b1);
                end
                2: begin
                    wr_txn(WR_BYTE, 1'b1);
                    rd_txn(int'($urandom_range(1, 3)));
                end
                default: begin
                    do begin
                        dev = 8'($urandom_range(0, 255));
                    end while (dev[7:1] == 7'h21);
                    tx_q.push_back(8'($urandom_range(0, 255)));
                    wr_txn(dev, 1'b1);
                end
            endcase
        end

        repeat (10) @(posedge clk);
        #1;
        check("wr_queue_drained", exp_wr_q.size(), 0);
        for (int i = 0; i < 256; i++) fab_check(8'(i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
